// File: rtl/ecdsa_exp_check_pkg.sv
// ecdsa_exp_check_pkg: shared defaults, response-entry field widths and counter helper
package ecdsa_exp_check_pkg;
  localparam int REAL_TIME_NBITS_DEF = 32;
  localparam int ECDSA_ID_NBITS_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int RSP_EXPIRED_W = 1;
  localparam int RSP_FUTURE_W = 1;
  localparam int STAT_W = 16;
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction
endpackage

// File: rtl/ecdsa_exp_fifo.sv
// ecdsa_exp_fifo: synchronous FIFO with occupancy count; pop on empty is ignored
module ecdsa_exp_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ecdsa_exp_check.sv
// ecdsa_exp_check: 3-stage timestamp expiry checker with credit-controlled output FIFO.
// Optional ECDSA_EXP_STATS_EN adds saturating checked/expired counters with stat_clr.
module ecdsa_exp_check
  import ecdsa_exp_check_pkg::*;
#(
  parameter int REAL_TIME_NBITS = REAL_TIME_NBITS_DEF,
  parameter int ID_NBITS = ECDSA_ID_NBITS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REAL_TIME_NBITS-1:0] default_exp_time,
  input  logic [REAL_TIME_NBITS-1:0] current_time,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ID_NBITS-1:0]        req_id,
  input  logic [REAL_TIME_NBITS-1:0] req_timestamp,
  input  logic [REAL_TIME_NBITS-1:0] req_exp_time,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_NBITS-1:0]        rsp_id,
  output logic                       rsp_expired,
  output logic                       rsp_future
`ifdef ECDSA_EXP_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [STAT_W-1:0]          stat_checked,
  output logic [STAT_W-1:0]          stat_expired
`endif
);
  localparam int N = REAL_TIME_NBITS;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = ID_NBITS + RSP_EXPIRED_W + RSP_FUTURE_W;
  logic accept;
  logic s1_v, s2_v;
  logic [ID_NBITS-1:0] s1_id, s2_id;
  logic [N-1:0] s1_ts, s1_eff, s2_ts;
  logic [N:0] s2_sum;
  logic s2_never;
  logic s3_future, s3_expired;
  logic [EW-1:0] fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [CW:0] credits_used;
  logic fifo_full, fifo_empty;
  // Credits count entries still in the pipe so a full FIFO can never be pushed
  assign credits_used = {1'b0, fifo_count} + (CW+1)'(s1_v) + (CW+1)'(s2_v);
  assign req_ready = credits_used < (CW+1)'(FIFO_DEPTH);
  assign accept = req_valid & req_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= accept;
      s2_v <= s1_v;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_id <= req_id;
      s1_ts <= req_timestamp;
      s1_eff <= (req_exp_time != '0) ? req_exp_time : default_exp_time;
    end
    if (s1_v) begin
      s2_id <= s1_id;
      s2_ts <= s1_ts;
      s2_sum <= {1'b0, s1_ts} + {1'b0, s1_eff};
      s2_never <= s1_eff == '0;
    end
  end
  // A carry out of the expiry sum means the deadline lies beyond the time range
  assign s3_future = s2_ts > current_time;
  assign s3_expired = ~s3_future & ~s2_never & ~s2_sum[N] & (current_time > s2_sum[N-1:0]);
  ecdsa_exp_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (s2_v),
    .pop  (rsp_ready),
    .din  ({s2_id, s3_expired, s3_future}),
    .dout (fifo_dout),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );
  assign rsp_valid = ~fifo_empty;
  assign {rsp_id, rsp_expired, rsp_future} = fifo_empty ? '0 : fifo_dout;
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(s2_v && fifo_full));
`ifdef ECDSA_EXP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_checked <= '0;
      stat_expired <= '0;
    end else if (s2_v) begin
      stat_checked <= sat_inc(stat_checked);
      stat_expired <= s3_expired ? sat_inc(stat_expired) : stat_expired;
    end
  end
`endif
endmodule

// File: tb/tb_ecdsa_exp_check.sv
// tb_ecdsa_exp_check: directed self-checking bench for ecdsa_exp_check
module tb_ecdsa_exp_check;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] default_exp_time = '0;
  logic [31:0] current_time = '0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [7:0] req_id = '0;
  logic [31:0] req_timestamp = '0;
  logic [31:0] req_exp_time = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [7:0] rsp_id;
  logic rsp_expired;
  logic rsp_future;
`ifdef ECDSA_EXP_STATS_EN
  logic stat_clr = 1'b0;
  logic [15:0] stat_checked;
  logic [15:0] stat_expired;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ecdsa_exp_check dut (
    .clk(clk),
    .rst(rst),
    .default_exp_time(default_exp_time),
    .current_time(current_time),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_id(req_id),
    .req_timestamp(req_timestamp),
    .req_exp_time(req_exp_time),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_expired(rsp_expired),
    .rsp_future(rsp_future)
`ifdef ECDSA_EXP_STATS_EN
    ,
    .stat_clr(stat_clr),
    .stat_checked(stat_checked),
    .stat_expired(stat_expired)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request in cycle C, samples rsp_valid at C+2 and the response at C+3, then pops it
  task automatic run_one(input logic [7:0] id, input logic [31:0] ts, input logic [31:0] ex,
                         output logic v2, output logic v3, output logic [7:0] id3,
                         output logic e3, output logic f3);
    req_valid = 1'b1;
    req_id = id;
    req_timestamp = ts;
    req_exp_time = ex;
    tick();
    req_valid = 1'b0;
    tick();
    v2 = rsp_valid;
    tick();
    v3 = rsp_valid;
    id3 = rsp_id;
    e3 = rsp_expired;
    f3 = rsp_future;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    checks++;
    if ({rsp_id, rsp_expired, rsp_future} !== 10'h0) begin
      failures++; $display("FAIL reset_rsp_fields got=%h want=0", {rsp_id, rsp_expired, rsp_future});
    end
  endtask

  task automatic test_default_exp();
    logic v2, v3, e, f;
    logic [7:0] id;
    default_exp_time = 32'd100;
    current_time = 32'd1101;
    run_one(8'h11, 32'd1000, 32'd0, v2, v3, id, e, f);
    checks++;
    if (v2 !== 1'b0) begin failures++; $display("FAIL latency_c2_valid got=%b want=0", v2); end
    checks++;
    if (v3 !== 1'b1) begin failures++; $display("FAIL latency_c3_valid got=%b want=1", v3); end
    checks++;
    if (id !== 8'h11) begin failures++; $display("FAIL default_id got=%h want=11", id); end
    checks++;
    if ({e, f} !== 2'b10) begin failures++; $display("FAIL default_expired got=%b want=10", {e, f}); end
    current_time = 32'd1100;
    run_one(8'h12, 32'd1000, 32'd0, v2, v3, id, e, f);
    checks++;
    if ({v3, e, f} !== 3'b100) begin failures++; $display("FAIL default_equal_boundary got=%b want=100", {v3, e, f}); end
  endtask

  task automatic test_explicit_exp();
    logic v2, v3, e, f;
    logic [7:0] id;
    default_exp_time = 32'd100;
    current_time = 32'd16;
    run_one(8'h21, 32'd10, 32'd5, v2, v3, id, e, f);
    checks++;
    if ({v3, e, f} !== 3'b110) begin failures++; $display("FAIL explicit_exp got=%b want=110", {v3, e, f}); end
    default_exp_time = 32'd0;
    current_time = 32'hFFFF_FFFF;
    run_one(8'h22, 32'd0, 32'd0, v2, v3, id, e, f);
    checks++;
    if ({v3, e, f} !== 3'b100) begin failures++; $display("FAIL never_expire got=%b want=100", {v3, e, f}); end
  endtask

  task automatic test_saturate_future();
    logic v2, v3, e, f;
    logic [7:0] id;
    default_exp_time = 32'd100;
    current_time = 32'hFFFF_FFFF;
    run_one(8'h31, 32'hFFFF_FFF0, 32'h20, v2, v3, id, e, f);
    checks++;
    if ({v3, e, f} !== 3'b100) begin failures++; $display("FAIL carry_saturate got=%b want=100", {v3, e, f}); end
    current_time = 32'd400;
    run_one(8'h32, 32'd500, 32'd0, v2, v3, id, e, f);
    checks++;
    if ({v3, e, f} !== 3'b101) begin failures++; $display("FAIL future got=%b want=101", {v3, e, f}); end
    checks++;
    if (id !== 8'h32) begin failures++; $display("FAIL future_id got=%h want=32", id); end
  endtask

  task automatic test_back_to_back();
    int accepted = 0;
    logic [7:0] held;
    default_exp_time = 32'd100;
    current_time = 32'd0;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_timestamp = 32'd0;
    req_exp_time = 32'd0;
    for (int i = 0; i < 8; i++) begin
      req_id = 8'h40 + 8'(accepted);
      if (req_ready) accepted++;
      tick();
    end
    req_valid = 1'b0;
    checks++;
    if (accepted != 4) begin failures++; $display("FAIL credits_accepted got=%0d want=4", accepted); end
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL credits_exhausted got=%b want=0", req_ready); end
    held = rsp_id;
    tick();
    checks++;
    if (rsp_id !== held || rsp_id !== 8'h40) begin
      failures++; $display("FAIL hold_stable got=%h want=40", rsp_id);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 8'h40 + 8'(i)) begin
        failures++; $display("FAIL drain_order[%0d] got=%b/%h want=1/%h", i, rsp_valid, rsp_id, 8'h40 + 8'(i));
      end
      if (i == 0) begin
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL credit_same_cycle got=%b want=0", req_ready); end
      end
      tick();
      if (i == 0) begin
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL credit_after_pop got=%b want=1", req_ready); end
      end
    end
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b want=0", rsp_valid); end
  endtask

  task automatic test_sampled_default();
    default_exp_time = 32'd100;
    current_time = 32'd50;
    req_valid = 1'b1;
    req_id = 8'h51;
    req_timestamp = 32'd0;
    req_exp_time = 32'd0;
    tick();
    req_valid = 1'b0;
    default_exp_time = 32'd10;
    tick();
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_expired, rsp_future} !== {1'b1, 8'h51, 2'b00}) begin
      failures++; $display("FAIL sampled_default got=%b/%h/%b%b want=1/51/00", rsp_valid, rsp_id, rsp_expired, rsp_future);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_flush();
    int seen = 0;
    default_exp_time = 32'd100;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_id = 8'h60 + 8'(i);
      tick();
    end
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL flush_req_ready got=%b want=1", req_ready); end
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL flush_no_rsp got=%0d want=0", seen); end
  endtask

`ifdef ECDSA_EXP_STATS_EN
  task automatic test_stats();
    logic v2, v3, e, f;
    logic [7:0] id;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    default_exp_time = 32'd10;
    current_time = 32'd100;
    run_one(8'h71, 32'd0, 32'd0, v2, v3, id, e, f);
    run_one(8'h72, 32'd50, 32'd0, v2, v3, id, e, f);
    run_one(8'h73, 32'd95, 32'd0, v2, v3, id, e, f);
    checks++;
    if (stat_checked !== 16'd3) begin failures++; $display("FAIL stat_checked got=%0d want=3", stat_checked); end
    checks++;
    if (stat_expired !== 16'd2) begin failures++; $display("FAIL stat_expired got=%0d want=2", stat_expired); end
    req_valid = 1'b1;
    req_id = 8'h74;
    req_timestamp = 32'd0;
    tick();
    req_valid = 1'b0;
    tick();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checks++;
    if ({stat_checked, stat_expired} !== 32'd0) begin
      failures++; $display("FAIL stat_clr_wins got=%0d/%0d want=0/0", stat_checked, stat_expired);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 8'h74) begin failures++; $display("FAIL stat_clr_push got=%b/%h want=1/74", rsp_valid, rsp_id); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_default_exp();
    test_explicit_exp();
    test_saturate_future();
    test_back_to_back();
    test_sampled_default();
    test_reset_flush();
`ifdef ECDSA_EXP_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
